// File: rtl/approx_mul_arbiter.sv
// Round-robin front end sharing one 32x32 approximate multiplier core among N_REQ
// requesters, with a LAT-deep backpressured result pipeline returning tagged, in-order responses.
module approx_mul_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LAT   = 1,
  parameter int unsigned IDW   = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [32*N_REQ-1:0]    req_x,
  input  logic [32*N_REQ-1:0]    req_y,
  output logic [31:0]            mul_x,
  output logic [31:0]            mul_y,
  input  logic [63:0]            mul_z,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [63:0]            rsp_z,
  output logic [IDW-1:0]         rsp_id,
  output logic                   busy,
  output logic [31:0]            op_count
);

  logic              stall;
  logic              accept;
  logic              found;
  logic [N_REQ-1:0]  grant;
  logic [IDW-1:0]    grant_id;
  logic [31:0]       sel_x;
  logic [31:0]       sel_y;
  int unsigned       scan_idx;

  logic [IDW-1:0]    ptr_q;
  logic              s0_v;
  logic [IDW-1:0]    s0_id;
  logic [31:0]       x_q;
  logic [31:0]       y_q;
  logic [31:0]       op_count_q;

  logic [LAT-1:0]    r_v;
  logic [63:0]       r_z  [LAT];
  logic [IDW-1:0]    r_id [LAT];

  // Only the output stage can stall; everything behind it advances in lockstep.
  assign stall = r_v[LAT-1] & ~rsp_ready;

  // Scan from ptr+1 upward (mod N_REQ); the first valid requester wins.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    sel_x    = '0;
    sel_y    = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      scan_idx = (32'(ptr_q) + k) % N_REQ;
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (!found && (i == scan_idx) && req_valid[i]) begin
          found    = 1'b1;
          grant[i] = 1'b1;
          grant_id = IDW'(i);
          sel_x    = req_x[32*i +: 32];
          sel_y    = req_y[32*i +: 32];
        end
      end
    end
  end

  assign req_ready = grant & {N_REQ{~stall & rst_n}};
  assign accept    = |req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q      <= IDW'(N_REQ - 1);
      s0_v       <= 1'b0;
      s0_id      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_q + {31'b0, accept};
      if (!stall) begin
        s0_v <= accept;
        // Operands are only reloaded on an accept so the core inputs stay quiet on bubbles.
        if (accept) begin
          s0_id <= grant_id;
          x_q   <= sel_x;
          y_q   <= sel_y;
          ptr_q <= grant_id;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v <= '0;
      for (int unsigned k = 0; k < LAT; k++) begin
        r_z[k]  <= '0;
        r_id[k] <= '0;
      end
    end else if (!stall) begin
      r_v[0] <= s0_v;
      if (s0_v) begin
        r_z[0]  <= mul_z;
        r_id[0] <= s0_id;
      end
      for (int unsigned k = 1; k < LAT; k++) begin
        r_v[k] <= r_v[k-1];
        if (r_v[k-1]) begin
          r_z[k]  <= r_z[k-1];
          r_id[k] <= r_id[k-1];
        end
      end
    end
  end

  assign mul_x     = x_q;
  assign mul_y     = y_q;
  assign rsp_valid = r_v[LAT-1];
  assign rsp_z     = r_z[LAT-1];
  assign rsp_id    = r_id[LAT-1];
  assign busy      = s0_v | (|r_v);
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_approx_mul_arbiter.sv
// Self-checking bench for approx_mul_arbiter: directed table, hand-written corner
// sequences, and a randomized run against a stage-list reference model.
module tb_approx_mul_arbiter;

  localparam int unsigned N   = 4;
  localparam int unsigned LAT = 1;
  localparam int unsigned IDW = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_x;
  logic [32*N-1:0]   req_y;
  logic [31:0]       mul_x;
  logic [31:0]       mul_y;
  logic [63:0]       mul_z;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [63:0]       rsp_z;
  logic [IDW-1:0]    rsp_id;
  logic              busy;
  logic [31:0]       op_count;
  logic              core_trunc;

  int n_tests = 0;
  int n_fail  = 0;

  approx_mul_arbiter #(.N_REQ(N), .LAT(LAT), .IDW(IDW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y),
    .mul_x(mul_x), .mul_y(mul_y), .mul_z(mul_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_z(rsp_z), .rsp_id(rsp_id),
    .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  // Core model: exact product, or product with the low 10 bits truncated.
  always_comb begin
    mul_z = 64'(mul_x) * 64'(mul_y);
    if (core_trunc) mul_z = mul_z & ~64'h3FF;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [31:0] x, input logic [31:0] y);
    req_x[32*i +: 32] = x;
    req_y[32*i +: 32] = y;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drain(input int cycles);
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  typedef struct {
    int          rq;
    logic [31:0] x;
    logic [31:0] y;
    logic        trunc;
    logic [63:0] exp_z;
  } vec_t;

  vec_t vecs [5];

  // Reference model state for the random run: stage 0 is the operand stage.
  logic        m_v  [LAT+1];
  logic [31:0] m_x  [LAT+1];
  logic [31:0] m_y  [LAT+1];
  int          m_id [LAT+1];
  int          m_ptr;
  logic [31:0] m_cnt;
  logic        pend [N];
  logic [31:0] px   [N];
  logic [31:0] py   [N];

  initial begin
    int       got_n;
    logic [63:0] got [3];
    logic     x3_taken;
    logic     stall_m;
    int       g;
    logic [N-1:0] exp_rdy;
    logic     any_v;

    rst_n = 1'b1; req_valid = '0; req_x = '0; req_y = '0;
    rsp_ready = 1'b1; core_trunc = 1'b0;

    // Reset values, with all requests asserted so req_ready gating is meaningful.
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'h0);
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_mul_x", 64'(mul_x), 64'h0);
    chk("reset_mul_y", 64'(mul_y), 64'h0);
    chk("reset_rsp_z", rsp_z, 64'h0);
    chk("reset_rsp_id", 64'(rsp_id), 64'h0);
    chk("reset_op_count", 64'(op_count), 64'h0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table: single requests through the core model.
    vecs[0] = '{rq: 2, x: 32'd3,          y: 32'd5,          trunc: 1'b0, exp_z: 64'd15};
    vecs[1] = '{rq: 0, x: 32'hFFFF_FFFF,  y: 32'hFFFF_FFFF,  trunc: 1'b1, exp_z: 64'hFFFF_FFFE_0000_0000};
    vecs[2] = '{rq: 3, x: 32'hFFFF_FFFF,  y: 32'hFFFF_FFFF,  trunc: 1'b0, exp_z: 64'hFFFF_FFFE_0000_0001};
    vecs[3] = '{rq: 1, x: 32'd0,          y: 32'd12345,      trunc: 1'b0, exp_z: 64'd0};
    vecs[4] = '{rq: 1, x: 32'h0001_0000,  y: 32'h0001_0000,  trunc: 1'b0, exp_z: 64'h1_0000_0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      core_trunc = vecs[i].trunc;
      set_req(vecs[i].rq, vecs[i].x, vecs[i].y);
      req_valid = N'(1) << vecs[i].rq;
      #1 chk($sformatf("tbl%0d_req_ready", i), 64'(req_ready), 64'(N'(1) << vecs[i].rq));
      @(negedge clk);
      req_valid = '0;
      #1 chk($sformatf("tbl%0d_op_count", i), 64'(op_count), 64'(i + 1));
      @(negedge clk);
      #1;
      chk($sformatf("tbl%0d_rsp_valid", i), 64'(rsp_valid), 64'h1);
      chk($sformatf("tbl%0d_rsp_z", i), rsp_z, vecs[i].exp_z);
      chk($sformatf("tbl%0d_rsp_id", i), 64'(rsp_id), 64'(vecs[i].rq));
    end
    core_trunc = 1'b0;
    drain(3);

    // Round-robin with all requesters continuously valid.
    do_reset();
    for (int i = 0; i < int'(N); i++) set_req(i, 32'(i + 1), 32'd10);
    rsp_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) @(negedge clk);
      req_valid = '1;
      #1;
      chk($sformatf("rr%0d_grant", c), 64'(req_ready), 64'(N'(1) << (c % N)));
      if (c >= 1) chk($sformatf("rr%0d_busy", c), 64'(busy), 64'h1);
      if (c >= 2) begin
        chk($sformatf("rr%0d_rsp_valid", c), 64'(rsp_valid), 64'h1);
        chk($sformatf("rr%0d_rsp_id", c), 64'(rsp_id), 64'((c - 2) % N));
        chk($sformatf("rr%0d_rsp_z", c), rsp_z, 64'(((c - 2) % N + 1) * 10));
      end
    end
    @(negedge clk);
    drain(3);

    // Backpressure: three back-to-back requests, output held for 5 cycles.
    req_valid = 4'b0010; set_req(1, 32'd1, 32'd7); rsp_ready = 1'b1;
    #1 chk("bp_acc1", 64'(req_ready), 64'h2);
    @(negedge clk);
    set_req(1, 32'd2, 32'd7); rsp_ready = 1'b0;
    #1 chk("bp_acc2", 64'(req_ready), 64'h2);
    @(negedge clk);
    set_req(1, 32'd3, 32'd7);
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      chk($sformatf("bp_stall%0d_ready", c), 64'(req_ready), 64'h0);
      chk($sformatf("bp_stall%0d_valid", c), 64'(rsp_valid), 64'h1);
      chk($sformatf("bp_stall%0d_z", c), rsp_z, 64'd7);
      chk($sformatf("bp_stall%0d_id", c), 64'(rsp_id), 64'd1);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    got_n = 0;
    x3_taken = 1'b0;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) @(negedge clk);
      req_valid = x3_taken ? 4'b0000 : 4'b0010;
      #1;
      if (rsp_valid && got_n < 3) begin
        got[got_n] = rsp_z;
        got_n++;
      end
      if (req_valid[1] && req_ready[1]) x3_taken = 1'b1;
    end
    chk("bp_x3_accepted", 64'(x3_taken), 64'h1);
    chk("bp_rsp_count", 64'(got_n), 64'd3);
    chk("bp_rsp0", got[0], 64'd7);
    chk("bp_rsp1", got[1], 64'd14);
    chk("bp_rsp2", got[2], 64'd21);
    @(negedge clk);
    #1 chk("bp_no_extra", 64'(rsp_valid), 64'h0);
    drain(2);

    // Reset with two operations in flight.
    set_req(2, 32'd9, 32'd9); set_req(3, 32'd4, 32'd4);
    req_valid = 4'b0100;
    @(negedge clk);
    req_valid = 4'b1000;
    @(negedge clk);
    req_valid = '0;
    #1 chk("rmf_busy_before", 64'(busy), 64'h1);
    #1 rst_n = 1'b0;
    req_valid = '1;
    #1;
    chk("rmf_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rmf_busy", 64'(busy), 64'h0);
    chk("rmf_req_ready", 64'(req_ready), 64'h0);
    chk("rmf_mul_x", 64'(mul_x), 64'h0);
    chk("rmf_rsp_z", rsp_z, 64'h0);
    chk("rmf_rsp_id", 64'(rsp_id), 64'h0);
    chk("rmf_op_count", 64'(op_count), 64'h0);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1 chk($sformatf("rmf_stale%0d", c), 64'(rsp_valid), 64'h0);
      @(negedge clk);
    end
    req_valid = '1;
    #1 chk("rmf_first_grant", 64'(req_ready), 64'h1);
    @(negedge clk);
    drain(3);

    // Counter wrap via backdoor.
    force dut.op_count_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.op_count_q;
    #1 chk("wrap_preset", 64'(op_count), 64'hFFFF_FFFF);
    set_req(0, 32'd2, 32'd2);
    req_valid = 4'b0001;
    @(negedge clk);
    req_valid = '0;
    #1 chk("wrap_zero", 64'(op_count), 64'h0);
    drain(3);

    // Randomized traffic against the reference model.
    do_reset();
    for (int s = 0; s <= int'(LAT); s++) begin
      m_v[s] = 1'b0; m_x[s] = '0; m_y[s] = '0; m_id[s] = 0;
    end
    for (int i = 0; i < int'(N); i++) begin
      pend[i] = 1'b0; px[i] = '0; py[i] = '0;
    end
    m_ptr = N - 1;
    m_cnt = '0;
    for (int c = 0; c < 400; c++) begin
      if (c > 0) @(negedge clk);
      for (int i = 0; i < int'(N); i++) begin
        if (!pend[i] && $urandom_range(0, 99) < 45) begin
          pend[i] = 1'b1;
          px[i] = $urandom;
          py[i] = $urandom;
        end
        req_valid[i] = pend[i];
        set_req(i, px[i], py[i]);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      stall_m = m_v[LAT] && !rsp_ready;
      g = -1;
      for (int k = 1; k <= int'(N); k++) begin
        if (g < 0 && pend[(m_ptr + k) % N]) g = (m_ptr + k) % N;
      end
      exp_rdy = (!stall_m && g >= 0) ? (N'(1) << g) : '0;
      any_v = 1'b0;
      for (int s = 0; s <= int'(LAT); s++) any_v = any_v | m_v[s];
      chk($sformatf("rnd%0d_req_ready", c), 64'(req_ready), 64'(exp_rdy));
      chk($sformatf("rnd%0d_rsp_valid", c), 64'(rsp_valid), 64'(m_v[LAT]));
      if (m_v[LAT]) begin
        chk($sformatf("rnd%0d_rsp_z", c), rsp_z, 64'(m_x[LAT]) * 64'(m_y[LAT]));
        chk($sformatf("rnd%0d_rsp_id", c), 64'(rsp_id), 64'(m_id[LAT]));
      end
      chk($sformatf("rnd%0d_busy", c), 64'(busy), 64'(any_v));
      chk($sformatf("rnd%0d_op_count", c), 64'(op_count), 64'(m_cnt));
      @(posedge clk);
      if (!stall_m) begin
        for (int s = int'(LAT); s >= 1; s--) begin
          m_v[s] = m_v[s-1]; m_x[s] = m_x[s-1]; m_y[s] = m_y[s-1]; m_id[s] = m_id[s-1];
        end
        m_v[0] = (g >= 0);
        if (g >= 0) begin
          m_x[0] = px[g]; m_y[0] = py[g]; m_id[0] = g;
          pend[g] = 1'b0;
          m_ptr = g;
          m_cnt = m_cnt + 32'd1;
        end
      end
    end
    @(negedge clk);
    drain(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
